// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// captures the returned word into the IF/ID register, with stall and redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc_out,
  input  logic [31:0] instr_in,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] RESET_PC_WORD = RESET_PC & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ACT_ADVANCE,
    ACT_HOLD,
    ACT_REDIRECT
  } action_t;

  action_t     action;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] count_q, count_d;

  // Redirect outranks stall so a taken branch is never lost behind a hazard.
  always_comb begin
    if (branch_taken)
      action = ACT_REDIRECT;
    else if (stall)
      action = ACT_HOLD;
    else
      action = ACT_ADVANCE;
  end

  always_comb begin
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    misalign_d   = 1'b0;
    count_d      = count_q;
    unique case (action)
      ACT_REDIRECT: begin
        pc_d         = {branch_target[31:2], 2'b00};
        ifid_pc_d    = '0;
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
        misalign_d   = (branch_target[1:0] != 2'b00);
      end
      ACT_HOLD: begin
      end
      ACT_ADVANCE: begin
        pc_d         = pc_q + 32'd4;
        ifid_pc_d    = pc_q;
        ifid_instr_d = instr_in;
        ifid_valid_d = 1'b1;
        count_d      = count_q + 32'd1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC_WORD;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      count_q      <= '0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      misalign_q   <= misalign_d;
      count_q      <= count_d;
    end
  end

  assign pc_out       = pc_q;
  assign ifid_pc      = ifid_pc_q;
  assign ifid_instr   = ifid_instr_q;
  assign ifid_valid   = ifid_valid_q;
  assign misalign_err = misalign_q;
  assign fetch_count  = count_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RISC-V datapath: owns the program counter, drives the word address into the combinational `Inst_Memory`, and captures the returned instruction into the IF/ID pipeline register for decode. Supports hazard-unit stalls and branch/jump redirects with flush. Also exposes a misaligned-target flag and a retired-fetch counter.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0013: bubble instruction (`addi x0,x0,0`) inserted on reset and flush.
- `clk`  in  1  single clock. All state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard unit. Hold PC and IF/ID contents.
- `branch_taken`  in  1  redirect request from EX.
- `branch_target`  in  32  redirect byte address.
- `pc_out`  out  32  current PC; drives `Inst_Memory.address`.
- `instr_in`  in  32  `Inst_Memory.instruction`; combinational function of `pc_out`.
- `ifid_pc`  out  32  PC of the instruction held in IF/ID.
- `ifid_instr`  out  32  instruction held in IF/ID.
- `ifid_valid`  out  1  IF/ID holds a real instruction, not a bubble.
- `misalign_err`  out  1  one-cycle pulse: the last accepted redirect had `branch_target[1:0]` != 0.
- `fetch_count`  out  32  number of valid instructions latched into IF/ID since reset.

## Operation
- Reset (`rst_n`=0, asynchronous): `pc_out`=`RESET_PC`, `ifid_pc`=0, `ifid_instr`=`NOP_INSTR`, `ifid_valid`=0, `misalign_err`=0, `fetch_count`=0. All outputs hold these values while `rst_n` is low.
- The PC is always word-aligned. Bits [1:0] of `pc_out` are always 0.
- Each cycle, exactly one of three actions occurs, in priority order:
  - **REDIRECT** (`branch_taken`=1, regardless of `stall`):
    - PC ← {`branch_target[31:2]`, 2'b00}.
    - IF/ID flushed: `ifid_instr`←`NOP_INSTR`, `ifid_valid`←0, `ifid_pc`←0.
    - `misalign_err`←(`branch_target[1:0]`!=0).
    - `fetch_count` unchanged.
  - **HOLD** (`stall`=1, `branch_taken`=0):
    - PC, `ifid_*` and `fetch_count` unchanged.
    - `misalign_err`←0.
  - **ADVANCE** (otherwise):
    - `ifid_pc`←`pc_out`, `ifid_instr`←`instr_in`, `ifid_valid`←1.
    - PC←`pc_out`+4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
    - `fetch_count`←`fetch_count`+1, wrapping at 2^32.
    - `misalign_err`←0.
- The instruction visible on `instr_in` is only sampled in ADVANCE; its value in other cycles is ignored.
- No internal FSM beyond these three per-cycle actions. The state is PC, the IF/ID register, the flag and the counter.

## Timing
- Fetch latency is 1 cycle: an instruction at address A appears on `ifid_instr` (with `ifid_pc`=A) on the edge after `pc_out`=A in a non-stalled, non-redirect cycle.
- Redirect penalty: the edge that accepts a redirect produces one bubble. The target instruction reaches IF/ID one edge later, if not stalled.
- A stall held for N cycles freezes all outputs for N edges. Fetch resumes at the same PC with no lost or duplicated instruction.
- Simultaneous `stall` and `branch_taken`: the redirect wins. PC is loaded and IF/ID is flushed.
- Back-to-back redirects: each one reloads PC and flushes. Only the last target is fetched.
- Reset asserted mid-stream: outputs return to reset values immediately, without waiting for a clock edge. The first ADVANCE after `rst_n` rises latches the instruction at `RESET_PC`.
- `misalign_err` is registered. It is high for exactly one cycle following the redirecting edge.

## Test plan
- **Reset then free run.** Memory preloaded: [0]=32'h003100B3, [1]=32'h40628233, [2]=32'h009473B3.
  - Release `rst_n`, no stall.
  - After edges 1, 2 and 3: `ifid_pc` = 0, 4, 8 respectively; `ifid_instr` = 003100B3, 40628233, 009473B3 respectively; `ifid_valid`=1; `fetch_count` = 1, 2, 3.
- **Stall.**
  - Assert `stall` for 3 cycles with `pc_out`=8: `pc_out` stays 8, `ifid_*` unchanged, `fetch_count` unchanged.
  - After release: next edge gives `ifid_pc`=8.
- **Redirect.**
  - `branch_taken`=1, `branch_target`=32'h18 while `pc_out`=12: next edge gives `pc_out`=24, `ifid_valid`=0, `ifid_instr`=32'h13.
  - Following edge: `ifid_pc`=24 with memory[6].
- **Redirect during stall, misaligned target.**
  - `stall`=1, `branch_taken`=1, `branch_target`=32'h0000_0022: `pc_out`=32'h20, IF/ID flushed.
  - `misalign_err`=1 for one cycle, then 0.
- **PC wrap.** Force a redirect to 32'hFFFF_FFFC, then ADVANCE: `ifid_pc`=FFFF_FFFC, `pc_out`=0.
- **Async reset mid-run.** Pull `rst_n` low between edges: `pc_out`=0, `ifid_valid`=0 and `fetch_count`=0 without waiting for a clock edge.
